octal_key_debounce: RTL and testbench

- Upstream stage of the octal-to-binary encoder.
- Takes 8 raw asynchronous key/switch lines, synchronizes and debounces them, and accepts a press only when exactly one line is active.
- Presents the accepted key as a registered one-hot byte (key_onehot) that drives the encoder's 8-bit `in` directly, plus valid/held/error status.
- Guarantees the encoder never sees a multi-hot or bouncing input.

---
 rtl/octal_key_debounce.sv | 108 ++++++++++
 tb/tb_octal_key_debounce.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/octal_key_debounce.sv
// octal_key_debounce: synchronize, debounce and one-hot-qualify eight key lines for the octal encoder
module octal_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    output logic [7:0] key_onehot,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_err
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t           state_q, state_d;
    logic [7:0]       s1_q, ks_q, sample_q, sample_d, onehot_q, onehot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d, err_q, err_d, single;
    assign single = (sample_q != 8'h00) && ((sample_q & (sample_q - 8'd1)) == 8'h00);
    // State, synchronizer and datapath registers; reset drops everything back to IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            s1_q     <= '0;
            ks_q     <= '0;
            sample_q <= '0;
            onehot_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= key_in;
            ks_q     <= s1_q;
            sample_q <= sample_d;
            onehot_q <= onehot_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end
    // Next-state logic: a press or release is accepted only after DEBOUNCE_CYCLES matching samples
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        onehot_d = onehot_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks_q != 8'h00) begin
                    state_d  = DEBOUNCE;
                    sample_d = ks_q;
                    cnt_d    = '0;
                end
            end
            DEBOUNCE: begin
                if (ks_q == sample_q) begin
                    if (cnt_q == LAST) begin
                        state_d  = single ? PRESSED : RELEASE;
                        onehot_d = single ? sample_q : 8'h00;
                        valid_d  = single;
                        err_d    = !single;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (ks_q == 8'h00) begin
                    state_d = IDLE;
                end else begin
                    sample_d = ks_q;
                    cnt_d    = '0;
                end
            end
            PRESSED: begin
                if (ks_q != onehot_q) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (ks_q == 8'h00) begin
                    if (cnt_q == LAST) begin
                        state_d  = IDLE;
                        onehot_d = 8'h00;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (ks_q == onehot_q && onehot_q != 8'h00) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Outputs: held stays up across a release bounce that returns to the accepted key
    always_comb begin
        key_onehot = onehot_q;
        key_valid  = valid_q;
        multi_err  = err_q;
        key_held   = (state_q == PRESSED) ||
                     (state_q == RELEASE && ks_q == onehot_q && onehot_q != 8'h00);
    end
endmodule

// File: tb/tb_octal_key_debounce.sv
// tb_octal_key_debounce: directed plus randomized checks against a run-length reference model
module tb_octal_key_debounce;
    localparam int D = 4;
    localparam int M_IDLE = 0, M_ARM = 1, M_DOWN = 2, M_UP = 3;
    logic       clk, rst;
    logic [7:0] key_in, key_onehot;
    logic       key_valid, key_held, multi_err;
    int         n_vec, n_bad, n_valid, n_err;
    int         m_mode, m_run, m_zeros;
    logic [7:0] m_s1, m_ks, m_samp, m_oh;
    logic       e_valid, e_err;

    octal_key_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_onehot(key_onehot),
        .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [7:0] v);
        enc = 8'hFF;
        for (int i = 0; i < 8; i++) if (v == (8'h01 << i)) enc = 8'(i);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_run = 0; m_zeros = 0;
        m_s1 = 0; m_ks = 0; m_samp = 0; m_oh = 0;
        e_valid = 0; e_err = 0;
    endtask

    // One clock edge of the reference: the decision uses the synchronized value seen before the edge
    task automatic model_edge(input logic [7:0] k);
        e_valid = 0; e_err = 0;
        if (m_mode == M_IDLE) begin
            if (m_ks != 0) begin m_mode = M_ARM; m_samp = m_ks; m_run = 1; end
        end else if (m_mode == M_ARM) begin
            if (m_ks == m_samp) begin
                m_run++;
                if (m_run == D + 1) begin
                    if ($countones(m_samp) == 1) begin m_oh = m_samp; e_valid = 1; m_mode = M_DOWN; end
                    else begin e_err = 1; m_mode = M_UP; m_zeros = 0; end
                end
            end else if (m_ks == 0) m_mode = M_IDLE;
            else begin m_samp = m_ks; m_run = 1; end
        end else if (m_mode == M_DOWN) begin
            if (m_ks != m_oh) begin m_mode = M_UP; m_zeros = 0; end
        end else begin
            if (m_ks == 0) begin
                m_zeros++;
                if (m_zeros == D) begin m_oh = 0; m_mode = M_IDLE; end
            end else if (m_ks == m_oh && m_oh != 0) m_mode = M_DOWN;
            else m_zeros = 0;
        end
        m_ks = m_s1;
        m_s1 = k;
    endtask

    task automatic compare_all();
        logic e_held;
        e_held = (m_mode == M_DOWN) || (m_mode == M_UP && m_ks == m_oh && m_oh != 0);
        check("onehot", key_onehot, m_oh);
        check("valid", {7'b0, key_valid}, {7'b0, e_valid});
        check("held", {7'b0, key_held}, {7'b0, e_held});
        check("err", {7'b0, multi_err}, {7'b0, e_err});
        check("onehot0", {7'b0, $onehot0(key_onehot)}, 8'h01);
        check("valid_err_excl", {7'b0, key_valid & multi_err}, 8'h00);
        if (key_valid) n_valid++;
        if (multi_err) n_err++;
    endtask

    task automatic tick(input logic [7:0] k);
        key_in = k;
        @(posedge clk);
        if (rst) model_reset(); else model_edge(k);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) tick(k);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; n_valid = 0; n_err = 0;
        rst = 1'b1; key_in = 8'hFF;
        model_reset();
        hold(8'hFF, 3);
        check("rst_onehot", key_onehot, 8'h00);
        check("rst_flags", {5'b0, key_valid, key_held, multi_err}, 8'h00);
        rst = 1'b0;
        hold(8'h00, 4);
        check("post_rst_onehot", key_onehot, 8'h00);

        n_valid = 0;
        key_in = 8'h10;
        for (int i = 1; i <= 20; i++) begin
            tick(8'h10);
            if (i == 7) check("press_valid_e7", {7'b0, key_valid}, 8'h01);
            if (i == 6) check("press_no_valid_e6", {7'b0, key_valid}, 8'h00);
        end
        check("press_pulses", 8'(n_valid), 8'd1);
        check("press_enc", enc(key_onehot), 8'd4);
        check("press_held", {7'b0, key_held}, 8'h01);
        hold(8'h00, 10);

        n_valid = 0;
        for (int i = 0; i < 12; i++) tick((i % 4) < 2 ? 8'h04 : 8'h00);
        hold(8'h00, 6);
        check("bounce_no_valid", 8'(n_valid), 8'd0);
        check("bounce_onehot", key_onehot, 8'h00);
        hold(8'h04, 10);
        check("bounce_then_press", 8'(n_valid), 8'd1);
        check("bounce_press_onehot", key_onehot, 8'h04);
        hold(8'h00, 10);

        n_valid = 0; n_err = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(8'h81);
            if (i == 7) check("multi_err_e7", {7'b0, multi_err}, 8'h01);
        end
        check("multi_err_pulses", 8'(n_err), 8'd1);
        check("multi_no_valid", 8'(n_valid), 8'd0);
        check("multi_onehot", key_onehot, 8'h00);
        hold(8'h00, 8);
        hold(8'h01, 10);
        check("multi_then_single", key_onehot, 8'h01);
        check("multi_then_valid", 8'(n_valid), 8'd1);
        hold(8'h00, 10);

        n_valid = 0;
        hold(8'h20, 10);
        tick(8'h00); tick(8'h20); tick(8'h00);
        for (int i = 1; i <= 12; i++) begin
            tick(8'h00);
            if (i == 2) check("rel_bounce_hold", key_onehot, 8'h20);
        end
        check("rel_cleared", key_onehot, 8'h00);
        check("rel_one_valid", 8'(n_valid), 8'd1);

        n_valid = 0;
        for (int b = 0; b < 8; b++) begin
            hold(8'h01 << b, 10);
            check("sweep_onehot", key_onehot, 8'h01 << b);
            hold(8'h00, 10);
        end
        check("sweep_pulses", 8'(n_valid), 8'd8);

        n_valid = 0;
        hold(8'h02, 4);
        rst = 1'b1; model_reset();
        #1;
        check("rst_mid_deb", {key_onehot[6:0], key_valid}, 8'h00);
        check("rst_mid_deb_flags", {6'b0, key_held, multi_err}, 8'h00);
        hold(8'h02, 2);
        rst = 1'b0;
        hold(8'h00, 4);
        check("rst_mid_deb_no_pulse", 8'(n_valid), 8'd0);
        hold(8'h08, 10);
        check("pre_rst_press", key_onehot, 8'h08);
        rst = 1'b1; model_reset();
        #1;
        check("rst_mid_press_async", key_onehot, 8'h00);
        check("rst_mid_press_held", {7'b0, key_held}, 8'h00);
        hold(8'h08, 2);
        rst = 1'b0;
        hold(8'h00, 4);

        for (int s = 0; s < 80; s++) begin
            int r;
            logic [7:0] v;
            r = $urandom_range(0, 3);
            v = (r == 0) ? 8'h00 : (r == 3) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            hold(v, $urandom_range(1, 10));
        end
        hold(8'h00, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
